// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit and its datapath:
// FSM states, opcode/funct constants, mux-select codes and control-word structs.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET,
        S_FETCH,
        S_FETCH_WAIT,
        S_IR_LOAD,
        S_DECODE,
        S_R_EXEC,
        S_R_WB,
        S_ADDI_EXEC,
        S_ADDI_WB,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WAIT,
        S_LW_WB,
        S_SW_WR,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR,
        S_DIV_CHECK,
        S_MD_START,
        S_MD_WAIT,
        S_MD_WB,
        S_EXC_EPC,
        S_EXC_WAIT,
        S_EXC_LOAD
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [2:0] PC_SRC_ALU    = 3'd0;
    localparam logic [2:0] PC_SRC_ALUOUT = 3'd1;
    localparam logic [2:0] PC_SRC_JUMP   = 3'd2;
    localparam logic [2:0] PC_SRC_REG_A  = 3'd3;
    localparam logic [2:0] PC_SRC_VECTOR = 3'd4;

    localparam logic [1:0] ALU_A_PC  = 2'd0;
    localparam logic [1:0] ALU_A_REG = 2'd1;

    localparam logic [1:0] ALU_B_REG      = 2'd0;
    localparam logic [1:0] ALU_B_FOUR     = 2'd1;
    localparam logic [1:0] ALU_B_SE16     = 2'd2;
    localparam logic [1:0] ALU_B_SE16_SH2 = 2'd3;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_SLT    = 3'd3;
    localparam logic [2:0] ALU_PASS_A = 3'd4;

    localparam logic [1:0] IORD_PC     = 2'd0;
    localparam logic [1:0] IORD_ALUOUT = 2'd1;
    localparam logic [1:0] IORD_EXC    = 2'd2;

    // Cause code selects vector byte 253 + cause.
    localparam logic [1:0] EXC_INVALID  = 2'd0;
    localparam logic [1:0] EXC_OVERFLOW = 2'd1;
    localparam logic [1:0] EXC_DIV_ZERO = 2'd2;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_SP = 2'd2;
    localparam logic [1:0] REG_DST_RA = 2'd3;

    localparam logic [1:0] M2R_ALUOUT  = 2'd0;
    localparam logic [1:0] M2R_MDR     = 2'd1;
    localparam logic [1:0] M2R_PC      = 2'd2;
    localparam logic [1:0] M2R_SP_INIT = 2'd3;

    localparam logic MD_SEL_MULT = 1'b0;
    localparam logic MD_SEL_DIV  = 1'b1;

    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       a_load;
        logic       b_load;
        logic       alu_out_load;
        logic       mdr_load;
        logic       epc_write;
        logic       hi_write;
        logic       lo_write;
        logic       md_start;
        logic       md_sel;
        logic [2:0] pc_source;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] iord;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
    } ctrl_out_t;

    typedef struct packed {
        state_t     state;
        logic [7:0] sp_init;
    } ctrl_dbg_t;

    function automatic logic [2:0] rtype_alu_op(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Next-state and Moore output decode for the multicycle control FSM; also
// computes the next exception cause for the registered exc_vec.
module control_unit_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state_q,
    input  logic [1:0] exc_vec_q,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       div_zero,
    input  logic       md_done,
    output state_t     state_d,
    output logic [1:0] exc_vec_d,
    output ctrl_out_t  ctrl
);

    logic arith_ovf_funct;

    assign arith_ovf_funct = (funct == FN_ADD) || (funct == FN_SUB);

    always_comb begin
        state_d   = state_q;
        exc_vec_d = exc_vec_q;
        ctrl      = '0;

        case (state_q)
            S_RESET: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_SP;
                ctrl.mem_to_reg = M2R_SP_INIT;
                state_d         = S_FETCH;
            end
            S_FETCH: begin
                ctrl.iord      = IORD_PC;
                ctrl.alu_src_a = ALU_A_PC;
                ctrl.alu_src_b = ALU_B_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_ALU;
                state_d        = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: state_d = S_IR_LOAD;
            S_IR_LOAD: begin
                ctrl.ir_write = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here while A/B load.
                ctrl.a_load       = 1'b1;
                ctrl.b_load       = 1'b1;
                ctrl.alu_out_load = 1'b1;
                ctrl.alu_src_a    = ALU_A_PC;
                ctrl.alu_src_b    = ALU_B_SE16_SH2;
                ctrl.alu_op       = ALU_ADD;
                state_d           = S_EXC_EPC;
                exc_vec_d         = EXC_INVALID;
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_SLT: state_d = S_R_EXEC;
                            FN_JR:   state_d = S_JR;
                            FN_MULT: state_d = S_MD_START;
                            FN_DIV:  state_d = S_DIV_CHECK;
                            default: state_d = S_EXC_EPC;
                        endcase
                    end
                    OP_ADDI:        state_d = S_ADDI_EXEC;
                    OP_LW, OP_SW:   state_d = S_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    default:        state_d = S_EXC_EPC;
                endcase
            end
            S_R_EXEC: begin
                ctrl.alu_src_a    = ALU_A_REG;
                ctrl.alu_src_b    = ALU_B_REG;
                ctrl.alu_op       = rtype_alu_op(funct);
                ctrl.alu_out_load = 1'b1;
                if (overflow && arith_ovf_funct) begin
                    state_d   = S_EXC_EPC;
                    exc_vec_d = EXC_OVERFLOW;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
                state_d         = S_FETCH;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a    = ALU_A_REG;
                ctrl.alu_src_b    = ALU_B_SE16;
                ctrl.alu_op       = ALU_ADD;
                ctrl.alu_out_load = 1'b1;
                if (overflow) begin
                    state_d   = S_EXC_EPC;
                    exc_vec_d = EXC_OVERFLOW;
                end else begin
                    state_d = S_ADDI_WB;
                end
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
                state_d         = S_FETCH;
            end
            S_ADDR: begin
                ctrl.alu_src_a    = ALU_A_REG;
                ctrl.alu_src_b    = ALU_B_SE16;
                ctrl.alu_op       = ALU_ADD;
                ctrl.alu_out_load = 1'b1;
                state_d           = (opcode == OP_SW) ? S_SW_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctrl.iord = IORD_ALUOUT;
                state_d   = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                ctrl.mdr_load = 1'b1;
                state_d       = S_LW_WB;
            end
            S_LW_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RT;
                ctrl.mem_to_reg = M2R_MDR;
                state_d         = S_FETCH;
            end
            S_SW_WR: begin
                ctrl.iord      = IORD_ALUOUT;
                ctrl.mem_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = ALU_A_REG;
                ctrl.alu_src_b = ALU_B_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PC_SRC_ALUOUT;
                ctrl.pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
                state_d        = S_FETCH;
            end
            S_JAL: begin
                // PC already holds the return address (+4 applied in FETCH).
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PC_SRC_JUMP;
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RA;
                ctrl.mem_to_reg = M2R_PC;
                state_d         = S_FETCH;
            end
            S_JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_REG_A;
                state_d        = S_FETCH;
            end
            S_DIV_CHECK: begin
                if (div_zero) begin
                    state_d   = S_EXC_EPC;
                    exc_vec_d = EXC_DIV_ZERO;
                end else begin
                    state_d = S_MD_START;
                end
            end
            S_MD_START: begin
                ctrl.md_start = 1'b1;
                state_d       = S_MD_WAIT;
            end
            S_MD_WAIT: begin
                if (md_done) begin
                    state_d = S_MD_WB;
                end
            end
            S_MD_WB: begin
                ctrl.hi_write = 1'b1;
                ctrl.lo_write = 1'b1;
                ctrl.md_sel   = (funct == FN_DIV) ? MD_SEL_DIV : MD_SEL_MULT;
                state_d       = S_FETCH;
            end
            S_EXC_EPC: begin
                // EPC gets the faulting instruction's address: PC was already advanced by 4.
                ctrl.alu_src_a = ALU_A_PC;
                ctrl.alu_src_b = ALU_B_FOUR;
                ctrl.alu_op    = ALU_SUB;
                ctrl.epc_write = 1'b1;
                ctrl.iord      = IORD_EXC;
                state_d        = S_EXC_WAIT;
            end
            S_EXC_WAIT: begin
                ctrl.iord = IORD_EXC;
                state_d   = S_EXC_LOAD;
            end
            S_EXC_LOAD: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_VECTOR;
                state_d        = S_FETCH;
                exc_vec_d      = EXC_INVALID;
            end
            default: state_d = S_RESET;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the MIPS-subset processor: holds the state and
// exception-cause registers and fans the decoded control word out to the datapath.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int SP_INIT = 227
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       div_zero,
    input  logic       md_done,
    output logic       pc_write,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       a_load,
    output logic       b_load,
    output logic       alu_out_load,
    output logic       mdr_load,
    output logic       epc_write,
    output logic       hi_write,
    output logic       lo_write,
    output logic       md_start,
    output logic       md_sel,
    output logic [2:0] pc_source,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] iord,
    output logic [1:0] exc_vec,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output ctrl_dbg_t  dbg
);

    state_t     state_q, state_d;
    logic [1:0] exc_vec_q, exc_vec_d;
    ctrl_out_t  ctrl;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RESET;
            exc_vec_q <= EXC_INVALID;
        end else begin
            state_q   <= state_d;
            exc_vec_q <= exc_vec_d;
        end
    end

    control_unit_decode u_decode (
        .state_q   (state_q),
        .exc_vec_q (exc_vec_q),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .md_done   (md_done),
        .state_d   (state_d),
        .exc_vec_d (exc_vec_d),
        .ctrl      (ctrl)
    );

    assign pc_write     = ctrl.pc_write;
    assign mem_write    = ctrl.mem_write;
    assign ir_write     = ctrl.ir_write;
    assign reg_write    = ctrl.reg_write;
    assign a_load       = ctrl.a_load;
    assign b_load       = ctrl.b_load;
    assign alu_out_load = ctrl.alu_out_load;
    assign mdr_load     = ctrl.mdr_load;
    assign epc_write    = ctrl.epc_write;
    assign hi_write     = ctrl.hi_write;
    assign lo_write     = ctrl.lo_write;
    assign md_start     = ctrl.md_start;
    assign md_sel       = ctrl.md_sel;
    assign pc_source    = ctrl.pc_source;
    assign alu_src_a    = ctrl.alu_src_a;
    assign alu_src_b    = ctrl.alu_src_b;
    assign alu_op       = ctrl.alu_op;
    assign iord         = ctrl.iord;
    assign reg_dst      = ctrl.reg_dst;
    assign mem_to_reg   = ctrl.mem_to_reg;
    assign exc_vec      = exc_vec_q;

    // SP_INIT is echoed so the datapath's reset-time stack value can be cross-checked.
    assign dbg.state   = state_q;
    assign dbg.sp_init = 8'(SP_INIT);

endmodule
